// File: rtl/pdec_row_unpack_if.sv
// Fetch-word and drawer-pixel handshakes of the pixel-decoder row unpacker.
// slave = the unpacker's view; master = the fetch stage / drawer side.
interface pdec_row_unpack_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_WIDTH = 16
);
  logic                   word_valid;
  logic [DATA_WIDTH-1:0]  word_data;
  logic                   word_ready;
  logic                   pix_req;
  logic                   pix_resp;
  logic [PIXEL_WIDTH-1:0] pixel;
  logic                   pdec_transparent;

  modport slave (
    input  word_valid, word_data, pix_req,
    output word_ready, pix_resp, pixel, pdec_transparent
  );

  modport master (
    output word_valid, word_data, pix_req,
    input  word_ready, pix_resp, pixel, pdec_transparent
  );
endinterface

// File: rtl/pdec_row_unpack.sv
// Unpacks packed 32-bit source words MSB-first into one pixel per cycle for the row drawer.
// Optional feature: define PDEC_TRANSPARENT_EN to flag zero-valued pixels as transparent.
module pdec_row_unpack #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_WIDTH = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [2:0]           bpp_sel,
  input  logic [CNT_WIDTH-1:0] row_len,
  pdec_row_unpack_if.slave     bus,
  output logic                 busy,
  output logic                 row_done
);
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_UNPACK, S_DONE} state_t;

  state_t                 r_state, w_state_next;
  logic [2:0]             r_bpp;        // normalised depth code 0..5
  logic [CNT_WIDTH-1:0]   r_remaining;  // pixels not yet consumed by the drawer
  logic [CNT_WIDTH-1:0]   r_to_load;    // pixels not yet placed in the output reg
  logic [DW-1:0]          r_shift;
  logic [5:0]             r_slot;       // unread pixels left in r_shift
  logic                   r_out_valid;
  logic [PIXEL_WIDTH-1:0] r_pixel;

  logic                   w_word_xfer;
  logic                   w_pix_xfer;
  logic                   w_load;
  logic [DW-1:0]          w_src;
  logic [PIXEL_WIDTH-1:0] w_pix;
  logic [4:0]             w_bpp;
  logic [5:0]             w_ppw;
  logic [5:0]             w_slot_base;

  function automatic logic [5:0] ppw_of(input logic [2:0] code);
    case (code)
      3'd0:    ppw_of = 6'd32;
      3'd1:    ppw_of = 6'd16;
      3'd2:    ppw_of = 6'd8;
      3'd3:    ppw_of = 6'd5;
      3'd4:    ppw_of = 6'd4;
      default: ppw_of = 6'd2;
    endcase
  endfunction

  function automatic logic [4:0] bpp_of(input logic [2:0] code);
    case (code)
      3'd0:    bpp_of = 5'd1;
      3'd1:    bpp_of = 5'd2;
      3'd2:    bpp_of = 5'd4;
      3'd3:    bpp_of = 5'd6;
      3'd4:    bpp_of = 5'd8;
      default: bpp_of = 5'd16;
    endcase
  endfunction

  assign w_bpp       = bpp_of(r_bpp);
  assign w_ppw       = ppw_of(r_bpp);
  assign w_word_xfer = bus.word_valid && (r_state == S_FETCH);
  assign w_pix_xfer  = bus.pix_req && r_out_valid;
  assign w_src       = (r_state == S_FETCH) ? bus.word_data : r_shift;
  assign w_slot_base = (r_state == S_FETCH) ? w_ppw : r_slot;

  // In FETCH the word's first pixel goes straight to an empty output reg; a
  // pixel still held there defers unpacking to UNPACK (the word-boundary bubble).
  assign w_load = (r_to_load != '0) &&
                  ((w_word_xfer && !r_out_valid) ||
                   ((r_state == S_UNPACK) && (r_slot != 6'd0) && (!r_out_valid || w_pix_xfer)));

  always_comb begin
    // NOTE: default first so every path assigns w_pix and no latch is inferred.
    w_pix = '0;
    case (r_bpp)
      3'd0:    w_pix = PIXEL_WIDTH'(w_src[DW-1 -: 1]);
      3'd1:    w_pix = PIXEL_WIDTH'(w_src[DW-1 -: 2]);
      3'd2:    w_pix = PIXEL_WIDTH'(w_src[DW-1 -: 4]);
      3'd3:    w_pix = PIXEL_WIDTH'(w_src[DW-1 -: 6]);
      3'd4:    w_pix = PIXEL_WIDTH'(w_src[DW-1 -: 8]);
      default: w_pix = PIXEL_WIDTH'(w_src[DW-1 -: 16]);
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = (row_len == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        if (w_word_xfer) w_state_next = S_UNPACK;
      end
      S_UNPACK: begin
        if (w_pix_xfer && (r_remaining == CNT_WIDTH'(1)))
          w_state_next = S_DONE;
        else if ((r_to_load != '0) && (r_slot == 6'd0))
          w_state_next = S_FETCH;
        else if (w_load && (r_slot == 6'd1) && (r_to_load > CNT_WIDTH'(1)))
          w_state_next = S_FETCH;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block take priority.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_bpp       <= 3'd0;
      r_remaining <= '0;
      r_to_load   <= '0;
      r_shift     <= '0;
      r_slot      <= 6'd0;
      r_out_valid <= 1'b0;
      r_pixel     <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && start) begin
        r_bpp       <= (bpp_sel > 3'd5) ? 3'd5 : bpp_sel;
        r_remaining <= row_len;
        r_to_load   <= row_len;
      end
      if (w_word_xfer) begin
        r_shift <= bus.word_data;
        r_slot  <= w_ppw;
      end
      if (w_load) begin
        r_shift   <= w_src << w_bpp;
        r_slot    <= w_slot_base - 6'd1;
        r_to_load <= r_to_load - CNT_WIDTH'(1);
        r_pixel   <= w_pix;
      end
      if (w_load)          r_out_valid <= 1'b1;
      else if (w_pix_xfer) r_out_valid <= 1'b0;
      if (w_pix_xfer && (r_remaining != '0))
        r_remaining <= r_remaining - CNT_WIDTH'(1);
    end
  end

`ifdef PDEC_TRANSPARENT_EN
  logic r_transp;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)    r_transp <= 1'b0;
    else if (w_load) r_transp <= (w_pix == '0);
  end

  assign bus.pdec_transparent = r_transp;
`else
  assign bus.pdec_transparent = 1'b0;
`endif

  assign bus.word_ready = (r_state == S_FETCH);
  assign bus.pix_resp   = r_out_valid;
  assign bus.pixel      = r_pixel;
  assign busy           = (r_state != S_IDLE);
  assign row_done       = (r_state == S_DONE);
endmodule
